// File: rtl/rotary_pkg.sv
// rotary_pkg: shared definitions for the rotary encoder front end.
//   - quadrature phase encodings ({a, b}) and the clockwise ring helper
//   - quadrature FSM state type
//   - sub-detent accumulator width and the accelerated increment
package rotary_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    localparam int SUB_W      = 4;
    localparam int SUB_DETENT = 4;
    localparam int ACCEL_INC  = 4;

    // Next phase when turning clockwise: 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] cw_next(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            PH_00:   nxt = PH_01;
            PH_01:   nxt = PH_11;
            PH_11:   nxt = PH_10;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/debounce.sv
// debounce: single-pin debouncer.
//   The output follows the input only after the input has differed from the
//   output for CYCLES consecutive clocks; any return to the output value
//   restarts the wait.
// Ports:
//   aclk  in  clock
//   reset in  asynchronous active-high reset (output clears to 0)
//   in    in  synchronized input
//   out   out debounced level
module debounce #(
    parameter int CYCLES = 1000
) (
    input  logic aclk,
    input  logic reset,
    input  logic in,
    output logic out
);

    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;

    always_comb begin
        cnt_d = CNT_W'(CYCLES);
        out_d = out_q;
        if (in != out_q) begin
            if (cnt_q == '0) begin
                out_d = in;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            cnt_q <= CNT_W'(CYCLES);
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/rotary_enc_ctrl.sv
// rotary_enc_ctrl: quadrature rotary-encoder front end.
//   Synchronizes and debounces A, B and the push switch, decodes the phase
//   ring into detent steps and keeps a clamped or wrapping position counter
//   plus a sticky illegal-transition flag.
// Optional feature: define ROTARY_ACCEL_EN to step by ACCEL_INC when two
//   same-direction detents are at most ACCEL_WINDOW clocks apart.
// Ports:
//   aclk, reset          clock, async active-high reset
//   enc_a, enc_b, enc_sw raw encoder pins
//   clear                sync clear of count and err
//   count                position
//   step_up, step_down   one-clock detent pulses
//   sw_state, sw_press   debounced switch level and press pulse
//   err                  sticky illegal-transition flag
//
// state    | meaning
// ST_INIT  | wait for debouncers to settle, then capture the current phase
// ST_TRACK | decode phase changes into sub-steps and detents
module rotary_enc_ctrl
    import rotary_pkg::*;
#(
    parameter int DEB_CYCLES   = 1000,
    parameter int CNT_WIDTH    = 8,
    parameter int CNT_MIN      = 0,
    parameter int CNT_MAX      = 255,
    parameter int WRAP         = 0,
    parameter int ACCEL_WINDOW = 100000
) (
    input  logic                 aclk,
    input  logic                 reset,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 enc_sw,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 step_up,
    output logic                 step_down,
    output logic                 sw_state,
    output logic                 sw_press,
    output logic                 err
);

    localparam int INIT_W = $clog2(DEB_CYCLES + 3);
    localparam int XW     = CNT_WIDTH + 1;
    localparam logic [XW-1:0] MIN_X   = XW'(CNT_MIN);
    localparam logic [XW-1:0] MAX_X   = XW'(CNT_MAX);
    localparam logic [XW-1:0] RANGE_X = XW'(CNT_MAX - CNT_MIN + 1);

    // Pin order in the synchronizer: {sw, b, a}.
    logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic       a_db, b_db, sw_db;
    logic [1:0] phase;

    always_comb begin
        sync1_d = {enc_sw, enc_b, enc_a};
        sync2_d = sync1_q;
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    debounce #(.CYCLES(DEB_CYCLES)) u_db_a  (.aclk(aclk), .reset(reset), .in(sync2_q[0]), .out(a_db));
    debounce #(.CYCLES(DEB_CYCLES)) u_db_b  (.aclk(aclk), .reset(reset), .in(sync2_q[1]), .out(b_db));
    debounce #(.CYCLES(DEB_CYCLES)) u_db_sw (.aclk(aclk), .reset(reset), .in(sync2_q[2]), .out(sw_db));

    assign phase = {a_db, b_db};

    // Quadrature FSM. sub is a two's-complement quarter-step accumulator.
    state_t            state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic [1:0]        prev_phase_q, prev_phase_d;
    logic [SUB_W-1:0]  sub_q, sub_d, sub_acc;
    logic              err_q, err_d;
    logic              step_up_q, step_up_d, step_down_q, step_down_d;

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        prev_phase_d = prev_phase_q;
        sub_d        = sub_q;
        sub_acc      = sub_q;
        err_d        = err_q;
        step_up_d    = 1'b0;
        step_down_d  = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == '0) begin
                    state_d      = ST_TRACK;
                    prev_phase_d = phase;
                    sub_d        = '0;
                end else begin
                    init_cnt_d = init_cnt_q - 1'b1;
                end
            end
            default: begin
                prev_phase_d = phase;
                if (phase == cw_next(prev_phase_q)) begin
                    sub_acc = sub_q + SUB_W'(1);
                end else if (prev_phase_q == cw_next(phase)) begin
                    sub_acc = sub_q - SUB_W'(1);
                end else if ((phase ^ prev_phase_q) == 2'b11) begin
                    sub_acc = '0;
                    err_d   = 1'b1;
                end
                // A detent is only counted when a full ring was walked
                // in one direction before landing back on 00.
                if (phase == PH_00 && prev_phase_q != PH_00) begin
                    step_up_d   = (sub_acc == SUB_W'(SUB_DETENT));
                    step_down_d = (sub_acc == SUB_W'(-SUB_DETENT));
                    sub_d       = '0;
                end else begin
                    sub_d = sub_acc;
                end
            end
        endcase
        if (clear) err_d = 1'b0;
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= INIT_W'(DEB_CYCLES + 2);
            prev_phase_q <= PH_00;
            sub_q        <= '0;
            err_q        <= 1'b0;
            step_up_q    <= 1'b0;
            step_down_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            prev_phase_q <= prev_phase_d;
            sub_q        <= sub_d;
            err_q        <= err_d;
            step_up_q    <= step_up_d;
            step_down_q  <= step_down_d;
        end
    end

    // Step size. The count is updated from the registered step pulse, so a
    // clear asserted while the pulse is visible overrides that step.
    logic fast;
    logic unused_accel;

`ifdef ROTARY_ACCEL_EN
    localparam int WIN_W = $clog2(ACCEL_WINDOW + 1);
    logic [WIN_W-1:0] win_q, win_d;
    logic             last_up_q, last_up_d;

    always_comb begin
        win_d     = win_q;
        last_up_d = last_up_q;
        if (step_up_q || step_down_q) begin
            win_d     = WIN_W'(ACCEL_WINDOW);
            last_up_d = step_up_q;
        end else if (win_q != '0) begin
            win_d = win_q - 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            win_q     <= '0;
            last_up_q <= 1'b0;
        end else begin
            win_q     <= win_d;
            last_up_q <= last_up_d;
        end
    end

    assign fast         = (win_q != '0) && (last_up_q == step_up_q);
    assign unused_accel = 1'b0;
`else
    assign fast         = 1'b0;
    assign unused_accel = ^ACCEL_WINDOW;
`endif

    logic [XW-1:0]        inc_x, cnt_x, sum_x, over_x, diff_x, short_x, res_x;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 sw_state_q, sw_state_d;

    assign inc_x = fast ? XW'(ACCEL_INC) : XW'(1);

    always_comb begin
        cnt_x   = {1'b0, count_q};
        sum_x   = cnt_x + inc_x;
        diff_x  = cnt_x - MIN_X;
        over_x  = '0;
        short_x = '0;
        res_x   = cnt_x;
        if (step_up_q) begin
            if (sum_x > MAX_X) begin
                over_x = sum_x - MAX_X - XW'(1);
                if (over_x >= RANGE_X) over_x = over_x - RANGE_X;
                res_x = (WRAP != 0) ? MIN_X + over_x : MAX_X;
            end else begin
                res_x = sum_x;
            end
        end else if (step_down_q) begin
            if (diff_x >= inc_x) begin
                res_x = cnt_x - inc_x;
            end else begin
                short_x = inc_x - diff_x - XW'(1);
                if (short_x >= RANGE_X) short_x = short_x - RANGE_X;
                res_x = (WRAP != 0) ? MAX_X - short_x : MIN_X;
            end
        end
        count_d    = clear ? CNT_WIDTH'(CNT_MIN) : res_x[CNT_WIDTH-1:0];
        sw_state_d = sw_db;
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            count_q    <= CNT_WIDTH'(CNT_MIN);
            sw_state_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            sw_state_q <= sw_state_d;
        end
    end

    assign count     = count_q;
    assign step_up   = step_up_q;
    assign step_down = step_down_q;
    assign err       = err_q;
    assign sw_state  = sw_db;
    assign sw_press  = sw_db & ~sw_state_q;

endmodule

// File: doc/rotary_enc_ctrl.md
Name: rotary_enc_ctrl

Overview:
Quadrature rotary-encoder front end for the HDR control panel.
- Conditions the raw A, B and push-switch pins: 2-flop synchronizer, then one debounce instance per pin.
- Decodes the quadrature phase sequence with a small FSM into detent steps.
- Maintains a clamped or wrapping position counter and a sticky error flag, which the register/UI logic consumes.

Parameters:
DEB_CYCLES, 1000, stable clocks required by each debounce instance before its output follows the input
CNT_WIDTH, 8, position counter width
CNT_MIN, 0, lower counter bound and reset/clear value
CNT_MAX, 255, upper counter bound (must satisfy CNT_MIN < CNT_MAX < 2^CNT_WIDTH)
WRAP, 0, 0 = saturate at bounds; 1 = wrap MAX->MIN and MIN->MAX
ACCEL_WINDOW, 100000, max clocks between same-direction detents that counts as "fast" (used only with ROTARY_ACCEL_EN)

Ports:
aclk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high; clears all state
enc_a  in  1  raw encoder phase A (async, bouncy)
enc_b  in  1  raw encoder phase B (async, bouncy)
enc_sw  in  1  raw push switch, 1 = pressed
clear  in  1  synchronous; count <= CNT_MIN, err <= 0
count  out  CNT_WIDTH  current position
step_up  out  1  one-clock pulse per CW detent
step_down  out  1  one-clock pulse per CCW detent
sw_state  out  1  debounced switch level
sw_press  out  1  one-clock pulse on debounced switch 0->1
err  out  1  sticky; set on illegal phase transition

Behaviour:
- Reset values: count = CNT_MIN; step_up, step_down, sw_press, sw_state and err = 0; FSM in INIT; synchronizer and debounce outputs = 0.
- Debounce: output takes the input value only after the input has been stable for DEB_CYCLES consecutive clocks.
- Phase latency: pin change to phase update = 2 (sync) + DEB_CYCLES + 1 clocks.
- phase = {a_db, b_db}.
- FSM states:
  - INIT: counts DEB_CYCLES+3 clocks, then loads prev_phase <= phase and sub <= 0, and moves to TRACK. No steps or errors in INIT.
  - TRACK: compare phase with prev_phase every clock.
- Transitions in TRACK:
  - CW ring 00->01->11->10->00 gives sub += 1.
  - CCW (reverse ring) gives sub -= 1.
  - No change: hold.
  - Both bits changing (00<->11, 01<->10): err <= 1, sub <= 0.
  - prev_phase <= phase every clock.
- sub is a signed 4-bit accumulator. On entry to phase 00 (detent):
  - sub == +4: step_up pulse.
  - sub == -4: step_down pulse.
  - Any other value: no step.
  - sub <= 0 in all three cases.
- Step pulses are registered, so they appear 1 clock after phase reaches 00.
- Counter update on a step: count ± inc, where inc = 1 (or the accelerated value, see Optional Feature).
- Counter bounds:
  - WRAP = 0: result is clamped to [CNT_MIN, CNT_MAX].
  - WRAP = 1: stepping past MAX lands on MIN, and past MIN lands on MAX.
  - Intermediate arithmetic is CNT_WIDTH+1 bits.
- Step pulses fire on every detected detent, even when count is already clamped.
- clear has priority over a same-cycle step: count = CNT_MIN, and the step pulse is still emitted.
- clear in INIT is honoured.
- Reset mid-operation: returns to INIT asynchronously and the position is lost.
- sw_press = sw_state & ~sw_state_q.

Optional Feature:
Macro ROTARY_ACCEL_EN.
- Defined: a saturating interval counter tracks the previous detent's time and direction. If the next detent is in the same direction and within ACCEL_WINDOW clocks, inc = 4; otherwise inc = 1. Clamp and wrap rules are unchanged (wrap is modulo the range).
- Undefined: inc is always 1, and ACCEL_WINDOW is unused with no interval counter synthesized.

Decomposition:
- Shared package rotary_pkg:
  - phase encodings PH_00, PH_01, PH_11, PH_10
  - FSM state typedef (ST_INIT, ST_TRACK)
  - SUB_W = 4
  - ACCEL_INC = 4
- Sub-module: the existing debounce (parameter CYCLES; ports aclk, reset, in, out), instantiated three times.
- Quadrature FSM and counter stay in rotary_enc_ctrl.

Test Plan:
All scenarios use DEB_CYCLES = 4 and hold each phase 20 clocks unless stated. Inputs idle at 00.
- Reset release, then 00->01->11->10->00 -> exactly one step_up pulse; count 0->1; err = 0.
- Reverse sequence from count = 1, then repeat -> two step_down pulses; count 1->0->0 (clamped, WRAP = 0). With WRAP = 1 and CNT_MAX = 255, the second step gives count = 255.
- Partial turn 00->01->11->01->00 -> no step pulse; count unchanged. Pins toggling every 2 clocks for 200 clocks, then returning to 00 -> no step, err = 0.
- Illegal jump 00->11 -> err = 1 within DEB_CYCLES+4 clocks; count unchanged. Then pulse clear -> err = 0.
- CNT_MAX = 3 with 5 CW detents -> 5 step_up pulses; count saturates at 3. clear asserted in the same cycle as the 6th step -> count = 0, step_up still pulses.
- enc_sw high 50 clocks -> single sw_press pulse; sw_state = 1. With ROTARY_ACCEL_EN and ACCEL_WINDOW = 200, two CW detents 150 clocks apart -> count 0->1->5.
